// File: rtl/sequenciador_cordic_q16_32_pkg.sv
// Shared definitions for the sine/cosine sequencer.
//   state_t         : sequencer FSM encoding
//   Q_*             : quadrant codes produced by the correction block
//   ONE             : 1.0 in Q16.32
//   quad_code_valid : true for the five codes the fixup understands
package sequenciador_cordic_q16_32_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CORR_START = 3'd1,
    CORR_WAIT  = 3'd2,
    CORD_START = 3'd3,
    CORD_WAIT  = 3'd4,
    FIXUP      = 3'd5,
    OUT_HOLD   = 3'd6,
    ERRO       = 3'd7
  } state_t;

  localparam logic [2:0] Q_0    = 3'b000;
  localparam logic [2:0] Q_90   = 3'b001;
  localparam logic [2:0] Q_180  = 3'b010;
  localparam logic [2:0] Q_180B = 3'b011;
  localparam logic [2:0] Q_270  = 3'b100;

  localparam logic [47:0] ONE = 48'h0001_0000_0000;

  function automatic logic quad_code_valid(input logic [2:0] q);
    return (q <= Q_270);
  endfunction

endpackage

// File: rtl/sequenciador_cordic_q16_32_if.sv
// Angle-in / result-out handshake bundle of the sequencer.
//   in_valid/in_ready/z_in                              : angle request (Q16.16)
//   out_valid/out_ready/sin_out/cos_out/quadrante_out/erro : result (Q16.32)
// slave = sequencer side, master = producer/consumer side.
interface sequenciador_cordic_q16_32_if #(
  parameter int WIDTH          = 32,
  parameter int INTERNAL_WIDTH = 48
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          z_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [INTERNAL_WIDTH-1:0] sin_out;
  logic [INTERNAL_WIDTH-1:0] cos_out;
  logic [2:0]                quadrante_out;
  logic                      erro;

  modport slave (
    input  in_valid, z_in, out_ready,
    output in_ready, out_valid, sin_out, cos_out, quadrante_out, erro
  );

  modport master (
    output in_valid, z_in, out_ready,
    input  in_ready, out_valid, sin_out, cos_out, quadrante_out, erro
  );
endinterface

// File: rtl/sequenciador_cordic_q16_32_fixup.sv
// Quadrant fixup: maps the first-octant CORDIC result (s, c) back to the
// original quadrant by swapping and/or negating. Purely combinational.
//   q            in  quadrant code from the correction block
//   s, c         in  core sine / cosine, Q16.32
//   sin_o, cos_o out corrected sine / cosine
//   invalid_code out q is not one of the five known codes (passthrough used)
module fixup_quadrante_q16_32
  import sequenciador_cordic_q16_32_pkg::*;
#(
  parameter int W = 48
) (
  input  logic [2:0]   q,
  input  logic [W-1:0] s,
  input  logic [W-1:0] c,
  output logic [W-1:0] sin_o,
  output logic [W-1:0] cos_o,
  output logic         invalid_code
);

  logic [W-1:0] neg_s;
  logic [W-1:0] neg_c;

  // Two's complement negate, wraps in W bits.
  assign neg_s = W'(0) - s;
  assign neg_c = W'(0) - c;

  always_comb begin
    sin_o        = s;
    cos_o        = c;
    invalid_code = !quad_code_valid(q);
    case (q)
      Q_90: begin
        sin_o = c;
        cos_o = neg_s;
      end
      Q_180, Q_180B: begin
        sin_o = neg_s;
        cos_o = neg_c;
      end
      Q_270: begin
        sin_o = neg_c;
        cos_o = s;
      end
      default: begin
        sin_o = s;
        cos_o = c;
      end
    endcase
  end

endmodule

// File: rtl/sequenciador_cordic_q16_32.sv
// Sequencer for the sine/cosine path: accepts one Q16.16 angle, runs the
// quadrant-correction block, then the CORDIC core, applies the quadrant
// fixup and presents the Q16.32 result. Each wait for a done pulse is
// bounded by a watchdog; expiry yields an erro result instead of hanging.
//   clk, rst              clock, synchronous active-high reset
//   bus (slave)           angle in / result out handshakes
//   corr_*                correction block start, operand and results
//   cordic_*              CORDIC core start, operand and results
//   busy                  high in every state except IDLE
//
// state      | meaning
// IDLE       | ready for a new angle
// CORR_START | one-cycle corr_enable pulse, watchdog cleared
// CORR_WAIT  | waiting for corr_done, watchdog counting
// CORD_START | one-cycle cordic_start pulse, watchdog cleared
// CORD_WAIT  | waiting for cordic_done, watchdog counting
// FIXUP      | register quadrant-corrected sin/cos
// OUT_HOLD   | result held until out_ready
// ERRO       | watchdog expired, register zero result with erro
module sequenciador_cordic_q16_32
  import sequenciador_cordic_q16_32_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int INTERNAL_WIDTH = 48,
  parameter int WAIT_MAX       = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  sequenciador_cordic_q16_32_if.slave bus,
  output logic                      corr_enable,
  output logic [WIDTH-1:0]          corr_z_in,
  input  logic [INTERNAL_WIDTH-1:0] corr_z_out,
  input  logic [2:0]                corr_quadrante,
  input  logic                      corr_done,
  output logic                      cordic_start,
  output logic [INTERNAL_WIDTH-1:0] cordic_z,
  input  logic [INTERNAL_WIDTH-1:0] cordic_sin,
  input  logic [INTERNAL_WIDTH-1:0] cordic_cos,
  input  logic                      cordic_done,
  output logic                      busy
);

  // Last watchdog value still inside the window: a wait lasts at most
  // WAIT_MAX cycles, and a done arriving in that last cycle still wins.
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(WAIT_MAX - 1);

  state_t                    state;
  logic [CNT_WIDTH-1:0]      wd_cnt;
  logic [2:0]                quad_q;
  logic [INTERNAL_WIDTH-1:0] s_q;
  logic [INTERNAL_WIDTH-1:0] c_q;
  logic [INTERNAL_WIDTH-1:0] fx_sin;
  logic [INTERNAL_WIDTH-1:0] fx_cos;
  logic                      fx_invalid;
  logic                      in_ready_int;

  assign in_ready_int = (state == IDLE);
  assign bus.in_ready = in_ready_int;

  fixup_quadrante_q16_32 #(.W(INTERNAL_WIDTH)) u_fixup (
    .q            (quad_q),
    .s            (s_q),
    .c            (c_q),
    .sin_o        (fx_sin),
    .cos_o        (fx_cos),
    .invalid_code (fx_invalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wd_cnt            <= '0;
      quad_q            <= '0;
      s_q               <= '0;
      c_q               <= '0;
      corr_enable       <= 1'b0;
      corr_z_in         <= '0;
      cordic_start      <= 1'b0;
      cordic_z          <= '0;
      busy              <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.erro          <= 1'b0;
      bus.sin_out       <= '0;
      bus.cos_out       <= '0;
      bus.quadrante_out <= '0;
    end else begin
      // Start strobes are single-cycle by default.
      corr_enable  <= 1'b0;
      cordic_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_int) begin
            corr_z_in   <= bus.z_in;
            corr_enable <= 1'b1;
            busy        <= 1'b1;
            state       <= CORR_START;
          end
        end
        CORR_START: begin
          wd_cnt <= '0;
          state  <= CORR_WAIT;
        end
        CORR_WAIT: begin
          if (corr_done) begin
            cordic_z     <= corr_z_out;
            quad_q       <= corr_quadrante;
            cordic_start <= 1'b1;
            state        <= CORD_START;
          end else begin
            wd_cnt <= wd_cnt + CNT_WIDTH'(1);
            if (wd_cnt == WD_LAST) state <= ERRO;
          end
        end
        CORD_START: begin
          wd_cnt <= '0;
          state  <= CORD_WAIT;
        end
        CORD_WAIT: begin
          if (cordic_done) begin
            // Core outputs are only guaranteed in the done cycle.
            s_q   <= cordic_sin;
            c_q   <= cordic_cos;
            state <= FIXUP;
          end else begin
            wd_cnt <= wd_cnt + CNT_WIDTH'(1);
            if (wd_cnt == WD_LAST) state <= ERRO;
          end
        end
        FIXUP: begin
          bus.sin_out       <= fx_sin;
          bus.cos_out       <= fx_cos;
          bus.quadrante_out <= quad_q;
          bus.erro          <= fx_invalid;
          bus.out_valid     <= 1'b1;
          state             <= OUT_HOLD;
        end
        OUT_HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.erro      <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        ERRO: begin
          bus.sin_out       <= '0;
          bus.cos_out       <= '0;
          bus.quadrante_out <= '0;
          bus.erro          <= 1'b1;
          bus.out_valid     <= 1'b1;
          state             <= OUT_HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_cordic_q16_32.sv
// Self-checking bench for sequenciador_cordic_q16_32 with behavioural stubs
// for the correction block and the CORDIC core. Expected results are pushed
// into a queue when an angle is issued; a monitor pops on each output
// handshake and compares.
module tb_sequenciador_cordic_q16_32;
  import sequenciador_cordic_q16_32_pkg::*;

  localparam int W    = 32;
  localparam int IW   = 48;
  localparam int WMAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          corr_enable, corr_done, cordic_start, cordic_done, busy;
  logic [W-1:0]  corr_z_in;
  logic [IW-1:0] corr_z_out, cordic_z, cordic_sin, cordic_cos;
  logic [2:0]    corr_quadrante;

  sequenciador_cordic_q16_32_if #(.WIDTH(W), .INTERNAL_WIDTH(IW)) bus ();

  sequenciador_cordic_q16_32 #(
    .WIDTH(W), .INTERNAL_WIDTH(IW), .WAIT_MAX(WMAX), .CNT_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .corr_enable    (corr_enable),
    .corr_z_in      (corr_z_in),
    .corr_z_out     (corr_z_out),
    .corr_quadrante (corr_quadrante),
    .corr_done      (corr_done),
    .cordic_start   (cordic_start),
    .cordic_z       (cordic_z),
    .cordic_sin     (cordic_sin),
    .cordic_cos     (cordic_cos),
    .cordic_done    (cordic_done),
    .busy           (busy)
  );

  typedef struct {
    logic [IW-1:0] s;
    logic [IW-1:0] c;
    logic [2:0]    q;
    logic          e;
    int            kind;  // 0: normal, 1: correction timeout, 2: core timeout
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Stub configuration and timestamps.
  logic [W-1:0]  cur_z;
  logic [IW-1:0] stub_cz, stub_s, stub_c;
  logic [2:0]    stub_cq;
  int            corr_lat = 5, core_lat = 4;
  logic          corr_respond = 1'b1, core_respond = 1'b1;
  int            en_cyc = 0, start_cyc = 0, done_cyc = 0;
  int            n_core_start = 0;
  logic          late_fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Correction block stub.
  initial begin
    corr_done      = 1'b0;
    corr_z_out     = '0;
    corr_quadrante = '0;
    forever begin
      @(negedge clk);
      if (corr_enable && !rst) begin
        en_cyc = cyc;
        check("corr_z_in", corr_z_in, cur_z);
        if (corr_respond) begin
          repeat (corr_lat) @(negedge clk);
          corr_z_out = stub_cz; corr_quadrante = stub_cq; corr_done = 1'b1;
          @(negedge clk);
          corr_done = 1'b0;
        end else begin
          // Late pulses: one while the error result is held, one in IDLE.
          repeat (12) @(negedge clk);
          corr_z_out = 48'h0000_DEAD_BEEF; corr_quadrante = Q_180B; corr_done = 1'b1;
          @(negedge clk);
          corr_done = 1'b0;
          repeat (4) @(negedge clk);
          corr_done = 1'b1;
          @(negedge clk);
          corr_done = 1'b0;
          late_fin  = 1'b1;
        end
      end
    end
  end

  // CORDIC core stub.
  initial begin
    cordic_done = 1'b0;
    cordic_sin  = '0;
    cordic_cos  = '0;
    forever begin
      @(negedge clk);
      if (cordic_start && !rst) begin
        n_core_start++;
        start_cyc = cyc;
        check("cordic_z", cordic_z, stub_cz);
        if (core_respond) begin
          repeat (core_lat) @(negedge clk);
          cordic_sin = stub_s; cordic_cos = stub_c; cordic_done = 1'b1;
          done_cyc   = cyc;
          @(negedge clk);
          cordic_done = 1'b0;
          cordic_sin  = 48'hAAAA_AAAA_AAAA;
          cordic_cos  = 48'h5555_5555_5555;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_out_valid: actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            case (exp_q[0].kind)
              0:       check("lat_core_done", 64'(cyc), 64'(done_cyc + 2));
              1:       check("lat_corr_timeout", 64'(cyc), 64'(en_cyc + 10));
              default: check("lat_core_timeout", 64'(cyc), 64'(start_cyc + 10));
            endcase
          end
        end
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sin_out", bus.sin_out, e.s);
          check("cos_out", bus.cos_out, e.c);
          check("quadrante_out", 64'(bus.quadrante_out), 64'(e.q));
          check("erro", 64'(bus.erro), 64'(e.e));
        end
        prev_v = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [W-1:0] z);
    int k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) timeout_fail("send_in_ready");
    cur_z        = z;
    bus.z_in     = z;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || bus.out_valid) timeout_fail("drain");
  endtask

  task automatic wait_out_valid();
    int k;
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) timeout_fail("wait_out_valid");
  endtask

  task automatic push(input logic [IW-1:0] es, input logic [IW-1:0] ec,
                      input logic [2:0] eq, input logic ee, input int kind);
    exp_t e;
    e.s = es; e.c = ec; e.q = eq; e.e = ee; e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic txn(input logic [W-1:0] z, input logic [IW-1:0] cz, input logic [2:0] cq,
                     input logic [IW-1:0] s, input logic [IW-1:0] c,
                     input logic [IW-1:0] es, input logic [IW-1:0] ec,
                     input logic [2:0] eq, input logic ee, input int kind);
    stub_cz = cz; stub_cq = cq; stub_s = s; stub_c = c;
    push(es, ec, eq, ee, kind);
    send(z);
    drain();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_erro"}, 64'(bus.erro), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sin_out"}, bus.sin_out, 64'd0);
    check({tag, "_cos_out"}, bus.cos_out, 64'd0);
    check({tag, "_quadrante_out"}, 64'(bus.quadrante_out), 64'd0);
    check({tag, "_corr_enable"}, 64'(corr_enable), 64'd0);
    check({tag, "_cordic_start"}, 64'(cordic_start), 64'd0);
    check({tag, "_corr_z_in"}, 64'(corr_z_in), 64'd0);
    check({tag, "_cordic_z"}, cordic_z, 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    int starts_before;
    bus.in_valid  = 1'b0;
    bus.z_in      = '0;
    bus.out_ready = 1'b1;
    cur_z = '0; stub_cz = '0; stub_cq = '0; stub_s = '0; stub_c = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    // Quadrant 0, z=0.
    txn(32'h0000_0000, 48'h0, Q_0, 48'h0, ONE, 48'h0, ONE, Q_0, 1'b0, 0);
    // ~pi/2 -> q=001: sin=c, cos=-s.
    txn(32'h0001_921F, 48'h0000_0000_0010, Q_90, 48'h0, ONE, ONE, 48'h0, Q_90, 1'b0, 0);
    // q=010: sin=-s, cos=-c.
    txn(32'h0003_243F, 48'h0000_8605_6000, Q_180, 48'h0000_8000_0000, 48'h0000_DDB3_D742,
        48'hFFFF_8000_0000, 48'hFFFF_224C_28BE, Q_180, 1'b0, 0);
    // q=100: sin=-c, cos=s.
    txn(32'h0004_B65F, 48'h0000_8605_6000, Q_270, 48'h0000_8000_0000, 48'h0000_DDB3_D742,
        48'hFFFF_224C_28BE, 48'h0000_8000_0000, Q_270, 1'b0, 0);
    // q=011 behaves like q=010.
    txn(32'h0003_8000, 48'h0000_1111_2222, Q_180B, 48'h0000_8000_0000, 48'h0000_DDB3_D742,
        48'hFFFF_8000_0000, 48'hFFFF_224C_28BE, Q_180B, 1'b0, 0);
    // Unknown code 101: passthrough, erro=1.
    txn(32'h0000_1000, 48'h0000_0000_1000, 3'b101, 48'h0000_8000_0000, 48'h0000_DDB3_D742,
        48'h0000_8000_0000, 48'h0000_DDB3_D742, 3'b101, 1'b1, 0);
    // q=001 with non-zero s: cos=-s.
    txn(32'h0001_A000, 48'h0000_0ABC_0000, Q_90, 48'h0000_8000_0000, 48'h0000_DDB3_D742,
        48'h0000_DDB3_D742, 48'hFFFF_8000_0000, Q_90, 1'b0, 0);

    // Done arriving in the last watchdog cycle of both waits still wins.
    corr_lat = WMAX; core_lat = WMAX;
    txn(32'h0000_2000, 48'h0000_2000_0000, Q_0, 48'h0000_4000_0000, 48'h0000_C000_0000,
        48'h0000_4000_0000, 48'h0000_C000_0000, Q_0, 1'b0, 0);
    corr_lat = 5; core_lat = 4;

    // Backpressure: result held 10 cycles, second angle refused.
    bus.out_ready = 1'b0;
    stub_cz = 48'h0000_0333_0000; stub_cq = Q_270;
    stub_s = 48'h0000_1234_5678; stub_c = 48'h0000_ABCD_EF01;
    push(48'hFFFF_5432_10FF, 48'h0000_1234_5678, Q_270, 1'b0, 0);
    send(32'h0005_0000);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      bus.z_in     = 32'h0000_7777;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_sin_out", bus.sin_out, 64'h0000_FFFF_5432_10FF);
      check("bp_cos_out", bus.cos_out, 64'h0000_0000_1234_5678);
      check("bp_quadrante_out", 64'(bus.quadrante_out), 64'(Q_270));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_corr_enable", 64'(corr_enable), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    drain();

    // Correction never answers: error result, late done pulses ignored.
    corr_respond  = 1'b0;
    late_fin      = 1'b0;
    starts_before = n_core_start;
    bus.out_ready = 1'b0;
    push(48'h0, 48'h0, Q_0, 1'b1, 1);
    send(32'h0000_1111);
    wait_out_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_out_valid_held", 64'(bus.out_valid), 64'd1);
      check("to_erro_held", 64'(bus.erro), 64'd1);
    end
    bus.out_ready = 1'b1;
    k = 0;
    while (!late_fin && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!late_fin) timeout_fail("late_done_stub");
    @(negedge clk);
    check("late_core_starts", 64'(n_core_start), 64'(starts_before));
    check("late_in_ready", 64'(bus.in_ready), 64'd1);
    check("late_busy", 64'(busy), 64'd0);
    drain();
    corr_respond = 1'b1;

    // Normal transaction after the timeout.
    txn(32'h0003_0000, 48'h0000_0100_0000, Q_180, 48'h0, ONE,
        48'h0, 48'hFFFF_0000_0000, Q_180, 1'b0, 0);

    // Reset during CORD_WAIT abandons the angle.
    core_lat = 6;
    stub_cz = 48'h0000_1357_9BDF; stub_cq = Q_90; stub_s = ONE; stub_c = 48'h0;
    send(32'h0002_2222);
    k = 0;
    while (!cordic_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cordic_start) timeout_fail("wait_cordic_start");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cleared("midrst");
    repeat (12) @(negedge clk);
    check("midrst_no_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_idle", 64'(bus.in_ready), 64'd1);
    core_lat = 4;

    // Core never answers.
    core_respond = 1'b0;
    txn(32'h0000_4444, 48'h0000_0444_0000, Q_90, 48'h0, 48'h0,
        48'h0, 48'h0, Q_0, 1'b1, 2);
    core_respond = 1'b1;

    // Final clean transaction.
    txn(32'h0001_8000, 48'h0000_0800_0000, Q_90, 48'h0000_2000_0000, 48'h0000_F000_0000,
        48'h0000_F000_0000, 48'hFFFF_E000_0000, Q_90, 1'b0, 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
